router_core_ctrl: RTL and testbench

- Control FSM for the token-ring router core; it sequences the 55-bit frame buffer and the RX/TX handshake blocks.
- Per received frame it chooses one action: deliver to the local node, forward downstream, drop, or consume the token.
- While holding the token it injects one pending local packet, then regenerates the token.
- On the master node it also runs a lost-token watchdog.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_token_watchdog.sv | 35 +++
 rtl/router_core_ctrl.sv | 129 ++++++++++++
 tb/tb_router_core_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the token-ring router core
package router_pkg;

  localparam int FRAME_W = 55;

  localparam logic [2:0] TYPE_TOKEN  = 3'b000;
  localparam logic [2:0] TYPE_DATA   = 3'b001;

  localparam logic [2:0] TXSEL_BUF   = 3'd0;
  localparam logic [2:0] TXSEL_TOKEN = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DROP,
    ST_DELIVER,
    ST_FWD_LOAD,
    ST_INJ_LOAD,
    ST_SEND,
    ST_TOK_SEND
  } state_e;

endpackage

// File: rtl/router_token_watchdog.sv
// rtl/router_token_watchdog.sv - lost-token idle counter, saturating at TOKEN_TIMEOUT-1
module router_token_watchdog #(
  parameter logic [15:0] TOKEN_TIMEOUT = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam logic [15:0] LIMIT = TOKEN_TIMEOUT - 16'd1;

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/router_core_ctrl.sv
// rtl/router_core_ctrl.sv - router core control FSM: deliver/forward/drop/inject decisions and
// token regeneration; every output is decoded from registered state only.
module router_core_ctrl
  import router_pkg::*;
#(
  parameter logic [3:0]  NODE_ADDR     = 4'd0,
  parameter logic        IS_MASTER     = 1'b0,
  parameter logic [15:0] TOKEN_TIMEOUT = 16'd1024
) (
  input  logic       Clk_R,
  input  logic       Rst,
  input  logic       rx_has_data,
  input  logic       bad_decode,
  input  logic [3:0] address,
  input  logic [2:0] data_type,
  input  logic       Packet_From_Node_Valid,
  input  logic       tx_ready,
  output logic       rc_ready,
  output logic       rc_has_data,
  output logic       buffer_select,
  output logic       buf_load,
  output logic [2:0] tx_data_select,
  output logic       Core_Load_Ack,
  output logic       Packet_To_Node_Valid,
  output logic [7:0] drop_cnt
);

  state_e     state_q, state_d;
  logic       token_pending_q, token_pending_d;
  logic       gap_q, gap_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  logic wd_expired;
  logic wd_clr;
  logic xfer;
  logic token_seen;
  logic regen;

  // gap_q blanks rc_has_data for the cycle after a transfer, even on SEND -> TOK_SEND
  assign rc_has_data = ((state_q == ST_SEND) || (state_q == ST_TOK_SEND)) && !gap_q;
  assign xfer        = rc_has_data && tx_ready;
  assign token_seen  = (state_q == ST_EVAL) && !bad_decode && (data_type == TYPE_TOKEN);
  assign regen       = IS_MASTER && (state_q == ST_IDLE) && !rx_has_data && wd_expired;
  assign wd_clr      = token_seen || regen;

  router_token_watchdog #(
    .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
  ) u_watchdog (
    .clk    (Clk_R),
    .rst    (Rst),
    .clr    (wd_clr),
    .expired(wd_expired)
  );

  always_comb begin
    state_d         = state_q;
    token_pending_d = token_pending_q;
    drop_cnt_d      = drop_cnt_q;
    gap_d           = xfer;
    case (state_q)
      ST_IDLE: begin
        if (rx_has_data) begin
          state_d = ST_EVAL;
        end else if (regen) begin
          state_d = ST_TOK_SEND;
        end
      end
      ST_EVAL: begin
        if (bad_decode) begin
          state_d = ST_DROP;
        end else if (data_type == TYPE_TOKEN) begin
          state_d = Packet_From_Node_Valid ? ST_INJ_LOAD : ST_FWD_LOAD;
        end else if ((data_type == TYPE_DATA) && (address == NODE_ADDR)) begin
          state_d = ST_DELIVER;
        end else begin
          state_d = ST_FWD_LOAD;
        end
      end
      ST_DROP: begin
        if (drop_cnt_q != 8'hff) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      ST_DELIVER:  state_d = ST_IDLE;
      ST_FWD_LOAD: state_d = ST_SEND;
      ST_INJ_LOAD: begin
        token_pending_d = 1'b1;
        state_d         = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          state_d = token_pending_q ? ST_TOK_SEND : ST_IDLE;
        end
      end
      ST_TOK_SEND: begin
        if (xfer) begin
          token_pending_d = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      state_q         <= ST_IDLE;
      token_pending_q <= 1'b0;
      gap_q           <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      token_pending_q <= token_pending_d;
      gap_q           <= gap_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign rc_ready             = (state_q == ST_DROP) || (state_q == ST_DELIVER) ||
                                (state_q == ST_FWD_LOAD) || (state_q == ST_INJ_LOAD);
  assign buf_load             = (state_q == ST_FWD_LOAD) || (state_q == ST_INJ_LOAD);
  assign buffer_select        = (state_q == ST_FWD_LOAD);
  assign Core_Load_Ack        = (state_q == ST_INJ_LOAD);
  assign Packet_To_Node_Valid = (state_q == ST_DELIVER);
  assign tx_data_select       = (state_q == ST_TOK_SEND) ? TXSEL_TOKEN : TXSEL_BUF;
  assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_router_core_ctrl.sv
// tb/tb_router_core_ctrl.sv - self-checking bench for router_core_ctrl
module tb_router_core_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, bad, pfv, txr;
  logic [3:0] addr;
  logic [2:0] dtype;

  logic       s_rr, s_has, s_bsel, s_bl, s_ack, s_ptnv;
  logic [2:0] s_tsel;
  logic [7:0] s_drop;
  logic       m_rr, m_has, m_bsel, m_bl, m_ack, m_ptnv;
  logic [2:0] m_tsel;
  logic [7:0] m_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_model = 0;

  always #5 clk = ~clk;

  router_core_ctrl #(.NODE_ADDR(4'd0), .IS_MASTER(1'b0), .TOKEN_TIMEOUT(16'd1024)) u_dut (
    .Clk_R(clk), .Rst(rst), .rx_has_data(rx), .bad_decode(bad), .address(addr),
    .data_type(dtype), .Packet_From_Node_Valid(pfv), .tx_ready(txr),
    .rc_ready(s_rr), .rc_has_data(s_has), .buffer_select(s_bsel), .buf_load(s_bl),
    .tx_data_select(s_tsel), .Core_Load_Ack(s_ack), .Packet_To_Node_Valid(s_ptnv),
    .drop_cnt(s_drop)
  );

  router_core_ctrl #(.NODE_ADDR(4'd0), .IS_MASTER(1'b1), .TOKEN_TIMEOUT(16'd16)) u_mst (
    .Clk_R(clk), .Rst(rst), .rx_has_data(rx), .bad_decode(bad), .address(addr),
    .data_type(dtype), .Packet_From_Node_Valid(pfv), .tx_ready(txr),
    .rc_ready(m_rr), .rc_has_data(m_has), .buffer_select(m_bsel), .buf_load(m_bl),
    .tx_data_select(m_tsel), .Core_Load_Ack(m_ack), .Packet_To_Node_Valid(m_ptnv),
    .drop_cnt(m_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b0; bad = 1'b0; pfv = 1'b0; txr = 1'b0; addr = '0; dtype = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drop_model = 0;
  endtask

  // 0 drop, 1 deliver, 2 forward, 3 inject -- straight from the frame rules
  function automatic int model_action(input logic b, input logic [3:0] a, input logic [2:0] t,
                                      input logic p);
    if (b) return 0;
    if (t == 3'd0) return p ? 3 : 2;
    if (t == 3'd1 && a == 4'd0) return 1;
    return 2;
  endfunction

  task automatic run_frame(input logic b, input logic [3:0] a, input logic [2:0] t,
                           input logic p, input int stall, input bit drop_pfv,
                           output int hi_cycles);
    int act, rr_n, nrr, nptnv, nack, nbl, first_hi, quiet, gap_err, stall_left, n;
    logic bsel_seen, prev_xfer, done;
    logic [2:0] sels[$];
    act = model_action(b, a, t, p);
    rr_n = 0; nrr = 0; nptnv = 0; nack = 0; nbl = 0; first_hi = 0; quiet = 0;
    gap_err = 0; hi_cycles = 0; bsel_seen = 1'b0; prev_xfer = 1'b0; done = 1'b0;
    stall_left = (stall > 0) ? stall : 0;
    sels.delete();
    bad = b; addr = a; dtype = t; pfv = p; rx = 1'b1;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (drop_pfv && n == 2) pfv = 1'b0;
      if (s_has && stall_left > 0) begin
        txr = 1'b0;
        stall_left--;
      end else if (s_has && stall >= 0) begin
        txr = 1'b1;
      end else begin
        txr = 1'($urandom_range(0, 1));
      end
      if (s_rr) begin nrr++; rr_n = n; rx = 1'b0; end
      if (s_ptnv) nptnv++;
      if (s_ack) nack++;
      if (s_bl) begin nbl++; bsel_seen = s_bsel; end
      if (s_has) begin
        hi_cycles++;
        if (first_hi == 0) first_hi = n;
      end
      if (prev_xfer && s_has) gap_err++;
      prev_xfer = s_has && txr;
      if (s_has && txr) sels.push_back(s_tsel);
      if (rr_n > 0 && !s_has) quiet++; else quiet = 0;
      done = (quiet >= 3);
    end
    rx = 1'b0; pfv = 1'b0; txr = 1'b0;
    if (act == 0 && drop_model < 255) drop_model++;
    chk("frame_done", 32'(done), 32'd1);
    chk("rc_ready_cnt", nrr, 1);
    chk("rc_ready_lat", rr_n, 2);
    chk("ptnv_cnt", nptnv, (act == 1) ? 1 : 0);
    chk("ack_cnt", nack, (act == 3) ? 1 : 0);
    chk("bufload_cnt", nbl, (act >= 2) ? 1 : 0);
    if (act >= 2) begin
      chk("buf_sel", 32'(bsel_seen), (act == 2) ? 1 : 0);
      chk("first_hi_lat", first_hi, 3);
    end
    chk("xfer_cnt", sels.size(), (act == 3) ? 2 : (act == 2) ? 1 : 0);
    if (sels.size() >= 1) chk("xfer0_sel", 32'(sels[0]), 0);
    if (act == 3 && sels.size() >= 2) chk("xfer1_sel", 32'(sels[1]), 1);
    chk("gap_after_xfer", gap_err, 0);
    chk("drop_cnt", 32'(s_drop), drop_model);
  endtask

  initial begin
    int hi, early, fwd, on_time;
    logic b, p, dp;
    logic [3:0] a;
    logic [2:0] t;

    rst = 1'b1;
    rx = 1'b0; bad = 1'b0; pfv = 1'b0; txr = 1'b0; addr = '0; dtype = '0;
    #1;
    chk("async_reset_outs", {s_rr, s_has, s_bsel, s_bl, s_tsel, s_ack, s_ptnv, s_drop}, 0);
    do_reset();
    @(negedge clk);
    chk("reset_outs", {s_rr, s_has, s_bsel, s_bl, s_tsel, s_ack, s_ptnv, s_drop}, 0);

    run_frame(1'b0, 4'd0, 3'd1, 1'b0, -1, 1'b0, hi);
    chk("deliver_no_tx", hi, 0);
    run_frame(1'b0, 4'd5, 3'd1, 1'b0, 4, 1'b0, hi);
    chk("hold_hi_cycles", hi, 5);
    run_frame(1'b0, 4'd3, 3'd0, 1'b1, -1, 1'b0, hi);
    run_frame(1'b0, 4'd0, 3'd0, 1'b1, -1, 1'b1, hi);
    run_frame(1'b0, 4'd0, 3'd0, 1'b0, -1, 1'b0, hi);
    run_frame(1'b0, 4'd0, 3'd6, 1'b1, -1, 1'b0, hi);

    for (int i = 0; i < 60; i++) begin
      b  = ($urandom_range(0, 4) == 0);
      t  = ($urandom_range(0, 2) == 0) ? 3'd0 :
           ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(2, 7));
      a  = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      p  = 1'($urandom_range(0, 1));
      dp = 1'($urandom_range(0, 1));
      run_frame(b, a, t, p, -1, dp, hi);
    end

    for (int i = 0; i < 300; i++) begin
      run_frame(1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0, -1, 1'b0, hi);
    end
    chk("drop_saturated", 32'(s_drop), 255);

    do_reset();
    repeat (15) @(negedge clk);
    chk("wd_no_regen_e15", 32'(m_has), 0);
    @(negedge clk);
    chk("wd_regen_e16", {m_has, m_tsel}, {1'b1, 3'd1});
    chk("nonmaster_no_regen", 32'(s_has), 0);
    txr = 1'b1;
    @(negedge clk);
    chk("wd_regen_done", 32'(m_has), 0);
    txr = 1'b0;

    do_reset();
    txr = 1'b1;
    repeat (9) @(negedge clk);
    bad = 1'b0; addr = 4'd2; dtype = 3'd0; pfv = 1'b0; rx = 1'b1;
    early = 0; fwd = 0; on_time = 0;
    for (int k = 10; k <= 27; k++) begin
      @(negedge clk);
      if (m_rr) rx = 1'b0;
      if (m_has && m_tsel == 3'd1 && k < 27) early++;
      if (m_has && m_tsel == 3'd0) fwd++;
      if (k == 27 && m_has && m_tsel == 3'd1) on_time++;
    end
    txr = 1'b0; rx = 1'b0;
    chk("wd_token_clears", early, 0);
    chk("wd_token_forwarded", fwd, 1);
    chk("wd_regen_after_clear", on_time, 1);

    do_reset();
    run_frame(1'b1, 4'd1, 3'd1, 1'b0, -1, 1'b0, hi);
    bad = 1'b0; addr = 4'd5; dtype = 3'd1; pfv = 1'b0; txr = 1'b0; rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    chk("send_before_rst", 32'(s_has), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_has", 32'(s_has), 0);
    @(negedge clk);
    rst = 1'b0;
    drop_model = 0;
    @(negedge clk);
    chk("post_rst_outs", {s_rr, s_has, s_bsel, s_bl, s_tsel, s_ack, s_ptnv, s_drop}, 0);
    run_frame(1'b0, 4'd0, 3'd1, 1'b0, -1, 1'b0, hi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
